// File: rtl/reg_bus_initiator_if.sv
// Command, response and peripheral register-bus signals of reg_bus_initiator.
// master: the initiator's view (drives strobes and responses).
// slave:  the requester/peripheral side's view.
interface reg_bus_initiator_if #(
  parameter int ADDR_W = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [3:0]        cmd_be;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [3:0]        reg_we;
  logic [3:0]        reg_re;
  logic [ADDR_W-1:0] reg_addr;
  logic [31:0]       reg_di;
  logic [31:0]       reg_do;
  logic              ready;

  modport master (
    input  cmd_valid, cmd_we, cmd_be, cmd_addr, cmd_wdata, rsp_ready, reg_do, ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, reg_we, reg_re, reg_addr, reg_di
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_be, cmd_addr, cmd_wdata, rsp_ready, reg_do, ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, busy, reg_we, reg_re, reg_addr, reg_di
  );
endinterface

// File: rtl/reg_bus_initiator.sv
// Single-outstanding register-bus initiator: accepts one read/write command,
// runs one strobed access with a per-access timeout, returns one response.
// Every output is a flop; ready and reg_do only feed next-state logic.
module reg_bus_initiator #(
  parameter int unsigned ADDR_W  = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input logic            clk,
  input logic            resetn,
  reg_bus_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              is_wr_q, is_wr_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [3:0]        reg_we_q, reg_we_d;
  logic [3:0]        reg_re_q, reg_re_d;
  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [31:0]       reg_di_q, reg_di_d;

  // Next-state and next-output computation; outputs are decided one edge
  // ahead so cmd_ready/busy can be flops that track the upcoming state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    cmd_ready_d = cmd_ready_q;
    busy_d      = busy_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    reg_we_d    = reg_we_q;
    reg_re_d    = reg_re_q;
    reg_addr_d  = reg_addr_q;
    reg_di_d    = reg_di_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          is_wr_d     = bus.cmd_we;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
          if (bus.cmd_we && (bus.cmd_be == 4'h0)) begin
            // Write with no byte lanes: reject without touching the bus.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d    = ACCESS;
            cnt_d      = '0;
            reg_addr_d = bus.cmd_addr;
            reg_di_d   = bus.cmd_wdata;
            reg_we_d   = bus.cmd_we ? bus.cmd_be : 4'h0;
            reg_re_d   = bus.cmd_we ? 4'h0 : 4'hF;
          end
        end
      end
      ACCESS: begin
        // ready wins over timeout in the final allowed cycle.
        if (bus.ready) begin
          state_d     = RESP;
          reg_we_d    = '0;
          reg_re_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = is_wr_q ? '0 : bus.reg_do;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = RESP;
          reg_we_d    = '0;
          reg_re_d    = '0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        rsp_valid_d = 1'b0;
        reg_we_d    = '0;
        reg_re_d    = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      reg_we_q    <= '0;
      reg_re_q    <= '0;
      reg_addr_q  <= '0;
      reg_di_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      cmd_ready_q <= cmd_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      reg_addr_q  <= reg_addr_d;
      reg_di_q    <= reg_di_d;
    end
  end

  assign bus.cmd_ready = cmd_ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.reg_re    = reg_re_q;
  assign bus.reg_addr  = reg_addr_q;
  assign bus.reg_di    = reg_di_q;

endmodule

// File: tb/tb_reg_bus_initiator.sv
// Bench for reg_bus_initiator: a peripheral responder with programmable
// ready latency, a transaction-level model of the expected outputs, a
// per-cycle compare process, and directed plus randomized commands.
module tb_reg_bus_initiator;

  localparam int unsigned TO = 16;

  logic clk;
  logic resetn;

  reg_bus_initiator_if #(.ADDR_W(4)) bus ();

  reg_bus_initiator #(.ADDR_W(4), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- peripheral responder ----------------
  // ready rises after rsp_delay strobe cycles; outside an access ready
  // toggles randomly, which the initiator must ignore.
  logic [31:0] mem [16];
  int unsigned rsp_delay = 0;
  int unsigned rcnt = 0;
  logic        noise = 1'b0;
  logic        strobe;

  always_comb begin
    strobe      = (|bus.reg_we) || (|bus.reg_re);
    bus.ready   = strobe ? (rcnt >= rsp_delay) : noise;
    bus.reg_do  = mem[bus.reg_addr];
  end

  always @(posedge clk) begin
    if (strobe === 1'b1 && bus.ready === 1'b0) rcnt <= rcnt + 1;
    else                                        rcnt <= 0;
    noise <= 1'($urandom);
  end

  // ---------------- transaction-level model ----------------
  // A command accepted at edge E occupies the bus for L cycles after E,
  // where L = min(ready latency + 1, TIMEOUT); the response follows and
  // is held until rsp_ready is seen.
  logic        m_busy = 1'b0;
  int unsigned m_c = 0;
  int unsigned m_L = 0;
  logic        m_we = 1'b0;
  logic [3:0]  m_be = 4'h0;
  logic [3:0]  m_addr = 4'h0;
  logic [31:0] m_di = 32'h0;
  logic [31:0] m_rd = 32'h0;
  logic        m_err = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      m_busy = 1'b0;
      m_addr = 4'h0;
      m_di   = 32'h0;
    end else if (!m_busy) begin
      if (bus.cmd_valid) begin
        m_busy = 1'b1;
        m_c    = 1;
        m_we   = bus.cmd_we;
        m_be   = bus.cmd_be;
        if (bus.cmd_we && bus.cmd_be == 4'h0) begin
          m_L   = 0;
          m_err = 1'b1;
          m_rd  = 32'h0;
        end else begin
          m_addr = bus.cmd_addr;
          m_di   = bus.cmd_wdata;
          m_L    = (rsp_delay + 1 < TO) ? rsp_delay + 1 : TO;
          m_err  = (rsp_delay >= TO);
          m_rd   = (!bus.cmd_we && !m_err) ? mem[bus.cmd_addr] : 32'h0;
        end
      end
    end else if (m_c > m_L && bus.rsp_ready) begin
      m_busy = 1'b0;
    end else if (m_c <= m_L) begin
      m_c++;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic strobing;
      logic exp_rv;
      strobing = m_busy && (m_c <= m_L);
      exp_rv   = m_busy && (m_c > m_L);
      chk("cmd_ready", bus.cmd_ready, !m_busy);
      chk("busy", bus.busy, m_busy);
      chk("reg_we", bus.reg_we, (strobing && m_we) ? m_be : 4'h0);
      chk("reg_re", bus.reg_re, (strobing && !m_we) ? 4'hF : 4'h0);
      chk("reg_addr", bus.reg_addr, m_addr);
      chk("reg_di", bus.reg_di, m_di);
      chk("rsp_valid", bus.rsp_valid, exp_rv);
      if (exp_rv) begin
        chk("rsp_rdata", bus.rsp_rdata, m_rd);
        chk("rsp_err", bus.rsp_err, m_err);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic bound_fail(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got no event expected event within bound at %0t", nm, $time);
  endtask

  // Present a command and return at edge+1 after it is taken.
  task automatic issue(input logic we, input logic [3:0] be, input logic [3:0] addr,
                       input logic [31:0] wd, input int unsigned dly);
    logic acc;
    int unsigned n;
    rsp_delay     = dly;
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = we;
    bus.cmd_be    = be;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.cmd_ready;
      @(posedge clk);
      #1;
      n++;
    end
    bus.cmd_valid = 1'b0;
    if (!acc) bound_fail("cmd_accept");
  endtask

  // Observe the access and response; hold rsp_ready low for 'hold' cycles.
  task automatic collect(input int unsigned hold, output int unsigned strobes,
                         output int unsigned lat, output logic [31:0] rd, output logic er);
    logic got;
    strobes = 0;
    lat     = 0;
    rd      = 32'h0;
    er      = 1'b0;
    got     = 1'b0;
    for (int unsigned c = 1; c <= 100 && !got; c++) begin
      @(negedge clk);
      if ((|bus.reg_we) || (|bus.reg_re)) strobes++;
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        lat = c;
        rd  = bus.rsp_rdata;
        er  = bus.rsp_err;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    if (!got) begin
      bound_fail("rsp_valid");
    end else begin
      for (int unsigned h = 0; h < hold; h++) @(negedge clk);
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int unsigned st, lt;
    logic [31:0] rd;
    logic        er;
    int unsigned dly_tab [9] = '{0, 1, 2, 3, 7, 14, 15, 16, 40};

    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[1] = 32'h0000_00FF;
    mem[2] = 32'hDEAD_BEEF;

    resetn        = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_we    = 1'b0;
    bus.cmd_be    = 4'h0;
    bus.cmd_addr  = 4'h0;
    bus.cmd_wdata = 32'h0;
    bus.rsp_ready = 1'b0;

    @(posedge clk);
    #1;
    chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_reg_addr", bus.reg_addr, 4'h0);
    chk("rst_reg_di", bus.reg_di, 32'h0);
    @(posedge clk);
    #1;

    // Write, registered ready: 2 strobe cycles, response 3 cycles after accept.
    issue(1'b1, 4'hF, 4'h0, 32'h0000_0001, 1);
    collect(0, st, lt, rd, er);
    chk("wr_strobes", st, 2);
    chk("wr_latency", lt, 3);
    chk("wr_rdata", rd, 32'h0);
    chk("wr_err", er, 1'b0);

    // Read, combinational ready.
    issue(1'b0, 4'h0, 4'h1, 32'h1234_5678, 0);
    collect(1, st, lt, rd, er);
    chk("rd_strobes", st, 1);
    chk("rd_latency", lt, 2);
    chk("rd_rdata", rd, 32'h0000_00FF);
    chk("rd_err", er, 1'b0);

    // Read to a silent address: timeout.
    issue(1'b0, 4'hF, 4'hF, 32'h0, 1000);
    collect(0, st, lt, rd, er);
    chk("to_strobes", st, 16);
    chk("to_rdata", rd, 32'h0);
    chk("to_err", er, 1'b1);

    // ready in the final allowed cycle is a success.
    issue(1'b0, 4'hF, 4'h2, 32'h0, 15);
    collect(0, st, lt, rd, er);
    chk("last_strobes", st, 16);
    chk("last_rdata", rd, 32'hDEAD_BEEF);
    chk("last_err", er, 1'b0);

    // ready one cycle too late is a timeout.
    issue(1'b0, 4'hF, 4'h2, 32'h0, 16);
    collect(0, st, lt, rd, er);
    chk("late_strobes", st, 16);
    chk("late_err", er, 1'b1);

    // Write with no byte enables.
    issue(1'b1, 4'h0, 4'h5, 32'hAAAA_5555, 0);
    collect(0, st, lt, rd, er);
    chk("be0_strobes", st, 0);
    chk("be0_latency", lt, 1);
    chk("be0_err", er, 1'b1);
    chk("be0_rdata", rd, 32'h0);

    // Response back-pressure with a second command waiting.
    issue(1'b0, 4'h0, 4'h2, 32'h0, 0);
    bus.cmd_valid = 1'b1;
    bus.cmd_we    = 1'b1;
    bus.cmd_be    = 4'h3;
    bus.cmd_addr  = 4'h7;
    bus.cmd_wdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1'b1);
      chk("hold_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
      chk("hold_cmd_ready", bus.cmd_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("after_hs_cmd_ready", bus.cmd_ready, 1'b1);
    chk("after_hs_reg_we", bus.reg_we, 4'h0);
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("second_cmd_reg_we", bus.reg_we, 4'h3);
    @(posedge clk);
    #1;
    collect(0, st, lt, rd, er);
    chk("second_cmd_err", er, 1'b0);

    // Reset in the 2nd ACCESS cycle of a write.
    issue(1'b1, 4'hF, 4'h9, 32'h1111_2222, 5);
    @(posedge clk);
    #1;
    resetn = 1'b0;
    @(negedge clk);
    chk("pre_rst_reg_we", bus.reg_we, 4'hF);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_reg_we", bus.reg_we, 4'h0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", bus.rsp_valid, 1'b0);
      chk("post_rst_cmd_ready", bus.cmd_ready, 1'b1);
    end
    @(posedge clk);
    #1;

    // Randomized commands checked by the model every cycle.
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [3:0]  be;
      we = 1'($urandom);
      be = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
      mem[$urandom_range(0, 15)] = $urandom;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(we, be, 4'($urandom), $urandom, dly_tab[$urandom_range(0, 8)]);
      collect($urandom_range(0, 3), st, lt, rd, er);
    end

    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

endmodule

// File: doc/reg_bus_initiator.md
Name: reg_bus_initiator

Overview:
- Bus initiator for the SoC peripheral register bus. It drives the reg_we/reg_re/reg_addr/reg_di strobes and consumes reg_do/ready from a register-mapped peripheral such as the counter and timer blocks.
- Accepts single-beat read/write commands on a valid/ready command port and returns exactly one response per command on a valid/ready response port.
- Adds a per-access timeout so a non-responding address cannot hang the requester.
- Used by the debug/command bridge and by the bench to exercise peripherals.

Parameters:
- ADDR_W, 4: width of cmd_addr and reg_addr.
- TIMEOUT, 16: maximum number of cycles the strobes stay asserted waiting for ready. Legal range is 2..65535.

Ports:
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  initiator can accept a command
- cmd_we  input  1  1 = write, 0 = read
- cmd_be  input  4  byte enables for writes
- cmd_addr  input  ADDR_W  register word address
- cmd_wdata  input  32  write data
- rsp_valid  output  1  response present
- rsp_ready  input  1  requester accepts response
- rsp_rdata  output  32  read data; 0 for writes and errors
- rsp_err  output  1  1 = timeout or illegal command
- busy  output  1  high whenever state is not IDLE
- reg_we  output  4  byte write strobes to peripheral
- reg_re  output  4  read strobes to peripheral
- reg_addr  output  ADDR_W  peripheral register address
- reg_di  output  32  peripheral write data
- reg_do  input  32  peripheral read data (combinational from peripheral)
- ready  input  1  peripheral access complete

Behaviour:
- Reset (resetn low at a rising edge): state=IDLE.
  - reg_we=0, reg_re=0, reg_addr=0, reg_di=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, timeout counter=0.
  - Reset mid-access or mid-response drops the command silently; strobes are low from the next cycle.
- All bus outputs are registered; no combinational path from ready or reg_do to any output.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready, latch the command.
  - Write with cmd_be==0: go to RESP with rsp_err=1, rsp_rdata=0, and no bus cycle.
  - Otherwise go to ACCESS. At the same edge, load reg_addr=cmd_addr and reg_di=cmd_wdata. Set reg_we=cmd_be for a write, or reg_re=4'b1111 for a read (cmd_be ignored on reads).
- ACCESS:
  - cmd_ready=0. Strobes, address and data are held stable.
  - The timeout counter starts at 0 on the first ACCESS cycle and increments each cycle.
  - ready sampled high at an edge:
    - Clear reg_we/reg_re at that edge and go to RESP.
    - Read: rsp_rdata=reg_do sampled at that edge, rsp_err=0.
    - Write: rsp_rdata=0, rsp_err=0.
  - ready low and counter==TIMEOUT-1: clear strobes, go to RESP with rsp_rdata=0, rsp_err=1.
  - ready high in the final allowed cycle takes priority over timeout, giving a success response.
  - Minimum access length: read with combinational ready = 1 strobe cycle; write with registered ready = 2 strobe cycles. A repeated write of identical data in the second cycle is acceptable.
  - ready observed while in IDLE or RESP is ignored.
- RESP:
  - rsp_valid=1, with rsp_rdata and rsp_err held stable until rsp_valid & rsp_ready.
  - On acceptance: rsp_valid=0, return to IDLE. A new command can be accepted the cycle after.
- Throughput: one outstanding command only. cmd_ready is low in ACCESS and RESP.
- reg_addr and reg_di keep their last value after an access. Only the strobes return to 0.

Test Plan:
- Write addr 0x0, data 0x0000_0001, be=4'hF, to a peripheral with registered write ready:
  - reg_we=4'hF for exactly 2 cycles, then 0.
  - rsp_valid with rsp_err=0, rsp_rdata=0.
  - Command-accept to rsp_valid = 3 cycles.
- Read addr 0x1 where the peripheral returns 0x0000_00FF with combinational ready:
  - reg_re=4'hF for 1 cycle.
  - rsp_rdata=0x0000_00FF, rsp_err=0.
- Read addr 0xF to a responder that never asserts ready, TIMEOUT=16:
  - reg_re high for exactly 16 cycles, then 0.
  - rsp_err=1, rsp_rdata=0.
- Write with be=0 → no strobe ever asserted; rsp_valid next cycle with rsp_err=1.
- Hold rsp_ready low for 5 cycles after a read of 0xDEAD_BEEF:
  - rsp_valid and rsp_rdata stay stable throughout.
  - cmd_ready=0 throughout.
  - A second cmd_valid is not accepted until the cycle after rsp handshake.
- Assert resetn=0 during the 2nd ACCESS cycle of a write:
  - Strobes are 0 the next cycle.
  - No response is ever issued.
  - cmd_ready=1 after reset release.
